ov7670_cfg_sequencer: RTL and testbench
=======================================

OV7670_CFG_SEQUENCER -- requirements
Module: ov7670_cfg_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst; all state SHALL update on the rising edge of clk only.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- DEV_ID, 8'h42, SCCB write ID.
- ROM_AW, 8, ROM address width.
- T_PWDN, 10000, cycles with pwdn high.
- T_RST, 10000, cycles with rst_n low.
- T_WAKE, 30000, cycles after rst_n release.
- T_DLY, 100000, cycles per delay entry.
- MAX_RETRY, 3, retries per entry after NACK.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- resend, in, 1, restart table walk (level sampled).
- rom_addr, out, ROM_AW, table address.
- rom_data, in, 16, {reg,data}; valid 1 cycle after rom_addr.
- sccb_req, out, 1, write request to SCCB master.
- sccb_id, out, 8, device ID.
- sccb_reg, out, 8, register address.
- sccb_dat, out, 8, register data.
- sccb_ack, in, 1, one-cycle pulse: write done, ACKed.
- sccb_nack, in, 1, one-cycle pulse: write done, NACKed.
- ov7670_rst_n, out, 1, sensor reset (active low).
- ov7670_pwdn, out, 1, sensor power-down.
- done, out, 1, sequence finished.
- error, out, 1, an entry exhausted its retries.

Function
REQ-004 States SHALL be PWDN, RSTL, WAKE, FETCH, DECODE, WRITE, DELAY, DONE.
REQ-005 PWDN: pwdn=1, rst_n=0 for T_PWDN cycles, then RSTL.
REQ-006 RSTL: pwdn=0, rst_n=0 for T_RST cycles, then WAKE.
REQ-007 WAKE: rst_n=1 for T_WAKE cycles, then FETCH with rom_addr=0.
REQ-008 FETCH SHALL hold rom_addr for one cycle; DECODE SHALL sample rom_data on the next cycle.
REQ-009 DECODE SHALL branch on rom_data:
- 16'hFFFF -> DONE.
- 16'hFFF0 -> DELAY.
- anything else -> WRITE, with sccb_reg=rom_data[15:8], sccb_dat=rom_data[7:0], sccb_id=DEV_ID.
REQ-010 WRITE SHALL assert sccb_req, holding sccb_id/reg/dat stable, until sccb_ack or sccb_nack is seen; sccb_req SHALL be low in the cycle after that pulse.
REQ-011 On sccb_ack, WRITE SHALL clear the retry counter, increment rom_addr, and go to FETCH.
REQ-012 On sccb_nack with retry count < MAX_RETRY, WRITE SHALL increment the retry count, drop sccb_req for one cycle, then re-request the same entry.
REQ-013 On sccb_nack with retry count = MAX_RETRY, WRITE SHALL set error (sticky until rst or resend), skip the entry, and continue.
REQ-014 DELAY SHALL wait T_DLY cycles, increment rom_addr, then go to FETCH.
REQ-015 If rom_addr reaches its maximum (2^ROM_AW-1) and that entry is not an end marker, the block SHALL process it, then enter DONE without wrapping.
REQ-016 DONE SHALL assert done=1, sccb_req=0, rst_n=1 and pwdn=0.
REQ-017 resend=1 while in DONE SHALL clear done and error, set rom_addr=0, and go to FETCH without re-running the power sequence.
REQ-018 resend=1 in any other state SHALL be ignored.
REQ-019 Each delay counter SHALL count from 0 to T_x-1 and then transition, so each state lasts exactly T_x cycles.
REQ-020 If sccb_ack and sccb_nack are both asserted in the same cycle, the block SHALL treat it as NACK.
REQ-021 sccb_ack or sccb_nack arriving outside WRITE SHALL be ignored.

Reset
REQ-022 rst=1 SHALL force state PWDN and clear all counters, with outputs: rom_addr=0, sccb_req=0, sccb_id=DEV_ID, sccb_reg=0, sccb_dat=0, ov7670_rst_n=0, ov7670_pwdn=1, done=0, error=0.
REQ-023 rst asserted mid-WRITE SHALL drop sccb_req the next cycle; the block SHALL NOT wait for an outstanding ack.

Verification
REQ-024 Power-up timing, with T_PWDN=4, T_RST=3, T_WAKE=5 -> pwdn high for 4 cycles, rst_n low for 7 cycles, and the first rom_addr=0 fetch 5 cycles after rst_n rises.
REQ-025 Table walk, with ROM {1280, 1204, FFFF} and an ack 3 cycles after each req -> two writes with (reg,dat)=(12,80) then (12,04), both with ID 42; then done=1 and sccb_req stays 0.
REQ-026 Retries, with MAX_RETRY=3 and NACK on every attempt of entry 0 -> 4 req pulses, then error=1, walk proceeds to entry 1, and done asserts with error still 1.
REQ-027 Delay entry, with ROM {FFF0, 1280, FFFF} and T_DLY=8 -> exactly 8 idle cycles after DECODE before the fetch of entry 1.
REQ-028 Resend: pulse resend in DONE -> done=0, error cleared, fetch at addr 0 next cycle, no PWDN/RSTL; resend pulsed during WRITE -> no effect.
REQ-029 rst mid-WRITE, plus simultaneous ack+nack -> sccb_req=0 the cycle after rst and the power sequence restarts; ack+nack together is treated as a retry.

Source files
------------

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 bring-up sequencer: power-down, reset and wake timing, then a walk of a {reg,data}
// ROM issuing SCCB writes with NACK retries (16'hFFF0 = delay entry, 16'hFFFF = end marker).
module ov7670_cfg_sequencer #(
    parameter logic [7:0] DEV_ID    = 8'h42,
    parameter int         ROM_AW    = 8,
    parameter int         T_PWDN    = 10000,
    parameter int         T_RST     = 10000,
    parameter int         T_WAKE    = 30000,
    parameter int         T_DLY     = 100000,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resend,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_dat,
    input  logic              sccb_ack,
    input  logic              sccb_nack,
    output logic              ov7670_rst_n,
    output logic              ov7670_pwdn,
    output logic              done,
    output logic              error
);
    localparam logic [31:0]       LP_PWDN_TC   = 32'(T_PWDN - 1);
    localparam logic [31:0]       LP_RST_TC    = 32'(T_RST - 1);
    localparam logic [31:0]       LP_WAKE_TC   = 32'(T_WAKE - 1);
    localparam logic [31:0]       LP_DLY_TC    = 32'(T_DLY - 1);
    localparam logic [7:0]        LP_MAX_RETRY = 8'(MAX_RETRY);
    localparam logic [15:0]       LP_END       = 16'hFFFF;
    localparam logic [15:0]       LP_DELAY     = 16'hFFF0;
    localparam logic [ROM_AW-1:0] LP_ADDR_ONE  = ROM_AW'(1);

    typedef enum logic [2:0] {
        S_PWDN, S_RSTL, S_WAKE, S_FETCH, S_DECODE, S_WRITE, S_DELAY, S_DONE
    } state_t;

    state_t            r_state, w_state_nx;
    logic [31:0]       r_cnt, w_cnt_nx;
    logic [7:0]        r_retry, w_retry_nx;
    logic              r_gap, w_gap_nx;
    logic [ROM_AW-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_reg, w_reg_nx;
    logic [7:0]        r_dat, w_dat_nx;
    logic              r_err, w_err_nx;
    logic              w_next_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWDN;
            r_cnt   <= '0;
            r_retry <= '0;
            r_gap   <= 1'b0;
            r_addr  <= '0;
            r_reg   <= '0;
            r_dat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_retry <= w_retry_nx;
            r_gap   <= w_gap_nx;
            r_addr  <= w_addr_nx;
            r_reg   <= w_reg_nx;
            r_dat   <= w_dat_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_retry_nx   = r_retry;
        w_gap_nx     = r_gap;
        w_addr_nx    = r_addr;
        w_reg_nx     = r_reg;
        w_dat_nx     = r_dat;
        w_err_nx     = r_err;
        w_next_entry = 1'b0;
        case (r_state)
            S_PWDN: begin
                if (r_cnt == LP_PWDN_TC) begin
                    w_state_nx = S_RSTL;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            S_RSTL: begin
                if (r_cnt == LP_RST_TC) begin
                    w_state_nx = S_WAKE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            S_WAKE: begin
                if (r_cnt == LP_WAKE_TC) begin
                    w_state_nx = S_FETCH;
                    w_cnt_nx   = '0;
                    w_addr_nx  = '0;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            S_FETCH: w_state_nx = S_DECODE;
            S_DECODE: begin
                if (rom_data == LP_END) begin
                    w_state_nx = S_DONE;
                end else if (rom_data == LP_DELAY) begin
                    w_state_nx = S_DELAY;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = S_WRITE;
                    w_reg_nx   = rom_data[15:8];
                    w_dat_nx   = rom_data[7:0];
                    w_gap_nx   = 1'b0;
                end
            end
            S_WRITE: begin
                // nack wins over a coincident ack; responses during the retry gap are ignored
                if (r_gap) begin
                    w_gap_nx = 1'b0;
                end else if (sccb_nack) begin
                    if (r_retry == LP_MAX_RETRY) begin
                        w_err_nx     = 1'b1;
                        w_retry_nx   = '0;
                        w_next_entry = 1'b1;
                    end else begin
                        w_retry_nx = r_retry + 8'd1;
                        w_gap_nx   = 1'b1;
                    end
                end else if (sccb_ack) begin
                    w_retry_nx   = '0;
                    w_next_entry = 1'b1;
                end
            end
            S_DELAY: begin
                if (r_cnt == LP_DLY_TC) begin
                    w_cnt_nx     = '0;
                    w_next_entry = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            S_DONE: begin
                if (resend) begin
                    w_err_nx   = 1'b0;
                    w_addr_nx  = '0;
                    w_state_nx = S_FETCH;
                end
            end
            default: w_state_nx = S_PWDN;
        endcase

        // the last ROM slot ends the walk instead of wrapping to address 0
        if (w_next_entry) begin
            if (r_addr == '1) begin
                w_state_nx = S_DONE;
            end else begin
                w_addr_nx  = r_addr + LP_ADDR_ONE;
                w_state_nx = S_FETCH;
            end
        end
    end

    assign rom_addr     = r_addr;
    assign sccb_req     = (r_state == S_WRITE) && !r_gap;
    assign sccb_id      = DEV_ID;
    assign sccb_reg     = r_reg;
    assign sccb_dat     = r_dat;
    assign ov7670_pwdn  = (r_state == S_PWDN);
    assign ov7670_rst_n = !((r_state == S_PWDN) || (r_state == S_RSTL));
    assign done         = (r_state == S_DONE);
    assign error        = r_err;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: ROM and SCCB responder models plus a table-walk reference
// that predicts the write list and error flag from the ROM contents and the NACK plan.
`timescale 1ns/1ps
module tb_ov7670_cfg_sequencer;
    localparam int         ROM_AW    = 4;
    localparam int         ROM_N     = 16;
    localparam int         T_PWDN    = 4;
    localparam int         T_RST     = 3;
    localparam int         T_WAKE    = 5;
    localparam int         T_DLY     = 8;
    localparam int         MAX_RETRY = 3;
    localparam int         RESP_LAT  = 3;
    localparam logic [7:0] DEV_ID    = 8'h42;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              resend = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_req;
    logic [7:0]        sccb_id, sccb_reg, sccb_dat;
    logic              sccb_ack, sccb_nack;
    logic              ov7670_rst_n, ov7670_pwdn, done, error;

    logic [15:0] rom [ROM_N];
    int          nack_plan [ROM_N];
    bit          both_plan [ROM_N];
    int          attempts [ROM_N];
    int          plan_gen = 0;
    logic [23:0] obs_q [$];
    logic [23:0] exp_q [$];
    bit          exp_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ov7670_cfg_sequencer #(
        .DEV_ID(DEV_ID), .ROM_AW(ROM_AW), .T_PWDN(T_PWDN), .T_RST(T_RST),
        .T_WAKE(T_WAKE), .T_DLY(T_DLY), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .resend(resend), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_id(sccb_id), .sccb_reg(sccb_reg), .sccb_dat(sccb_dat),
        .sccb_ack(sccb_ack), .sccb_nack(sccb_nack), .ov7670_rst_n(ov7670_rst_n),
        .ov7670_pwdn(ov7670_pwdn), .done(done), .error(error)
    );

    // synchronous ROM: data for the address seen in one cycle appears in the next
    initial begin
        logic [ROM_AW-1:0] addr_d;
        addr_d   = '0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            rom_data = rom[addr_d];
            addr_d   = rom_addr;
        end
    end

    // SCCB slave: answers RESP_LAT cycles into each request, NACKing per plan
    initial begin
        int age;
        int last_gen;
        int a;
        sccb_ack  = 1'b0;
        sccb_nack = 1'b0;
        age       = 0;
        last_gen  = -1;
        forever begin
            @(negedge clk);
            if (plan_gen != last_gen) begin
                foreach (attempts[i]) attempts[i] = 0;
                last_gen = plan_gen;
            end
            sccb_ack  = 1'b0;
            sccb_nack = 1'b0;
            if (sccb_req !== 1'b1) begin
                age = 0;
            end else begin
                age++;
                if (age == RESP_LAT) begin
                    a = int'(rom_addr);
                    if (attempts[a] < nack_plan[a]) begin
                        sccb_nack = 1'b1;
                        sccb_ack  = both_plan[a];
                    end else begin
                        sccb_ack = 1'b1;
                    end
                    attempts[a]++;
                    age = 0;
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sccb_req === 1'b1 && !prev) obs_q.push_back({sccb_id, sccb_reg, sccb_dat});
            prev = (sccb_req === 1'b1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_walk();
        exp_q.delete();
        exp_err = 1'b0;
        for (int a = 0; a < ROM_N; a++) begin
            int tries;
            if (rom[a] == 16'hFFFF) break;
            if (rom[a] != 16'hFFF0) begin
                tries = (nack_plan[a] > MAX_RETRY) ? MAX_RETRY + 1 : nack_plan[a] + 1;
                for (int k = 0; k < tries; k++) exp_q.push_back({DEV_ID, rom[a]});
                if (nack_plan[a] > MAX_RETRY) exp_err = 1'b1;
            end
        end
    endtask

    task automatic check_walk(input int base, input string tag);
        int n_obs;
        model_walk();
        n_obs = obs_q.size() - base;
        chk({tag, "_nreq"}, 32'(n_obs), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_obs; i++)
            chk({tag, "_txn"}, 32'(obs_q[base + i]), 32'(exp_q[i]));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (sccb_req !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 32'(sccb_req), 32'd1);
    endtask

    // called with rst high at a falling edge; releases it and times the power sequence
    task automatic power_up(input string tag);
        int n;
        int k;
        rst = 1'b0;
        n = 1;
        tick();
        while (ov7670_pwdn === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_pwdn_cycles"}, 32'(n), 32'(T_PWDN));
        while (ov7670_rst_n === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_rstn_low_cycles"}, 32'(n), 32'(T_PWDN + T_RST));
        k = 0;
        while (ov7670_rst_n === 1'b1 && sccb_req !== 1'b1 && k < 100) begin
            k++;
            tick();
        end
        // wake time, then one FETCH and one DECODE cycle before the first request
        chk({tag, "_wake_to_req"}, 32'(k), 32'(T_WAKE + 2));
        chk({tag, "_first_addr"}, 32'(rom_addr), 32'd0);
    endtask

    task automatic start_resend(input string tag, output int base);
        base   = obs_q.size();
        resend = 1'b1;
        tick();
        resend = 1'b0;
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_err_clr"}, 32'(error), 32'd0);
        chk({tag, "_addr0"}, 32'(rom_addr), 32'd0);
        chk({tag, "_no_pwr"}, 32'({ov7670_pwdn, ov7670_rst_n}), 32'b01);
    endtask

    task automatic load_rom3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        for (int a = 0; a < ROM_N; a++) begin
            rom[a]       = 16'hFFFF;
            nack_plan[a] = 0;
            both_plan[a] = 1'b0;
        end
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        plan_gen++;
    endtask

    task automatic make_random_rom(input bit with_end);
        int endpos;
        logic [15:0] v;
        endpos = with_end ? int'($urandom_range(14, 3)) : ROM_N;
        for (int a = 0; a < ROM_N; a++) begin
            v = 16'($urandom);
            if (a == endpos) v = 16'hFFFF;
            else if (a != 0 && $urandom_range(7, 0) == 0) v = 16'hFFF0;
            else if (v >= 16'hFFF0) v = v ^ 16'h8000;
            rom[a]       = v;
            nack_plan[a] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 1)) : 0;
            both_plan[a] = ($urandom_range(1, 0) == 1);
        end
        plan_gen++;
    endtask

    initial begin
        int base;
        int n;
        load_rom3(16'h1280, 16'h1204, 16'hFFFF);
        repeat (3) tick();

        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_req", 32'(sccb_req), 32'd0);
        chk("rst_id", 32'(sccb_id), 32'h42);
        chk("rst_reg_dat", 32'({sccb_reg, sccb_dat}), 32'd0);
        chk("rst_pins", 32'({ov7670_rst_n, ov7670_pwdn}), 32'b01);
        chk("rst_flags", 32'({done, error}), 32'b00);

        base = obs_q.size();
        power_up("pwr");
        wait_done("walk");
        check_walk(base, "walk");
        chk("walk_first_txn", 32'(obs_q[base]), 32'h421280);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sccb_req !== 1'b0) n++;
        end
        chk("done_req_quiet", 32'(n), 32'd0);
        chk("done_hold", 32'({done, ov7670_rst_n, ov7670_pwdn}), 32'b110);

        load_rom3(16'h1280, 16'h1204, 16'hFFFF);
        nack_plan[0] = 99;
        start_resend("retry", base);
        wait_done("retry");
        check_walk(base, "retry");
        chk("retry_err_sticky", 32'(error), 32'd1);

        load_rom3(16'hFFF0, 16'h1280, 16'hFFFF);
        start_resend("dly", base);
        n = 1;
        tick();
        while (rom_addr == '0 && n < 100) begin
            n++;
            tick();
        end
        chk("dly_cycles_at_addr0", 32'(n), 32'(2 + T_DLY));
        wait_done("dly");
        check_walk(base, "dly");

        for (int it = 0; it < 2; it++) begin
            make_random_rom(it == 1);
            start_resend("rnd", base);
            wait_req("rnd");
            resend = 1'b1;
            tick();
            resend = 1'b0;
            chk("rnd_resend_in_write", 32'(done), 32'd0);
            wait_done("rnd");
            check_walk(base, "rnd");
            if (it == 0) chk("rnd_no_wrap_addr", 32'(rom_addr), 32'(ROM_N - 1));
        end

        load_rom3(16'h1280, 16'h1204, 16'hFFFF);
        nack_plan[0] = 1;
        both_plan[0] = 1'b1;
        start_resend("both", base);
        wait_done("both");
        check_walk(base, "both");

        plan_gen++;
        start_resend("abort", base);
        wait_req("abort");
        rst = 1'b1;
        tick();
        chk("abort_req_drop", 32'(sccb_req), 32'd0);
        chk("abort_pins", 32'({ov7670_rst_n, ov7670_pwdn}), 32'b01);
        chk("abort_addr", 32'(rom_addr), 32'd0);
        plan_gen++;
        base = obs_q.size();
        power_up("pwr2");
        wait_done("rewalk");
        check_walk(base, "rewalk");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
